// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the cache-side and memory-side handshake signals of mem_arbiter.
//   slave  : view taken by the arbiter (takes cache requests and memory
//            responses, drives readies, fill data and the memory request).
//   master : view taken by the environment (caches plus main memory).
// Signals
//   ic_req/ic_addr -> ic_ready/ic_rdata           icache line fills
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_ready/dc_rdata
//                                                 dcache fills and write-backs
//   mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata
//                                                 single main-memory port
//   busy, err                                     arbiter status
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [LINE_W-1:0] ic_rdata;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [LINE_W-1:0] dc_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    logic              busy;
    logic              err;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
               mem_ack, mem_rdata,
        output ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, busy, err
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
               mem_ack, mem_rdata,
        input  ic_ready, ic_rdata, dc_ready, dc_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates icache line fills and dcache fills/write-backs onto the single
//   main-memory port, one transaction in flight. A watchdog aborts a
//   transaction that memory never acknowledges and raises a sticky err.
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous, active-low reset
//   bus  : mem_arbiter_if.slave (cache requests/responses, memory port,
//          busy and err status)
// Parameters
//   ADDR_W  : byte-address width
//   LINE_W  : cache line width in bits
//   TIMEOUT : WAIT cycles allowed before the watchdog aborts (1..65535)
// Build option
//   MEM_ARBITER_ROUND_ROBIN_EN : when defined, simultaneous requests are
//   granted alternately; otherwise the dcache always wins a tie.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W)'((1 << OFF_W) - 1));
    // Counter value during the TIMEOUT-th WAIT cycle.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [15:0]       waitCnt;
    logic              srcDc;     // owner of the transaction in flight
    logic              reqWe;
    logic [ADDR_W-1:0] reqAddr;
    logic [LINE_W-1:0] reqWdata;
    logic [LINE_W-1:0] icRdata;
    logic [LINE_W-1:0] dcRdata;
    logic              errFlag;
    logic              anyReq;
    logic              grantDc;

    function automatic logic [ADDR_W-1:0] alignAddr(input logic [ADDR_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

    assign anyReq = bus.ic_req | bus.dc_req;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // Pointer names the side that wins the next tie; flips on every grant.
    logic favourDc;

    always_comb begin
        if (bus.ic_req && bus.dc_req) grantDc = favourDc;
        else                          grantDc = bus.dc_req;
    end

    always_ff @(posedge clk) begin
        if (!rst)                         favourDc <= 1'b1;
        else if (state == IDLE && anyReq) favourDc <= ~grantDc;
    end
`else
    // dcache holds the older instruction, so it wins every tie.
    assign grantDc = bus.dc_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            srcDc    <= 1'b0;
            reqWe    <= 1'b0;
            reqAddr  <= '0;
            reqWdata <= '0;
            icRdata  <= '0;
            dcRdata  <= '0;
            errFlag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    waitCnt <= '0;
                    if (anyReq) begin
                        state    <= WAIT;
                        srcDc    <= grantDc;
                        reqWe    <= grantDc & bus.dc_we;
                        reqAddr  <= alignAddr(grantDc ? bus.dc_addr : bus.ic_addr);
                        reqWdata <= grantDc ? bus.dc_wdata : '0;
                    end
                end
                WAIT: begin
                    // An ack in the final watchdog cycle still counts as success.
                    if (bus.mem_ack) begin
                        if (!reqWe) begin
                            if (srcDc) dcRdata <= bus.mem_rdata;
                            else       icRdata <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end else if (waitCnt == LAST_WAIT) begin
                        errFlag <= 1'b1;
                        if (srcDc) dcRdata <= '0;
                        else       icRdata <= '0;
                        state <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                RESP: begin
                    waitCnt <= '0;
                    state   <= IDLE;
                end
                default: begin
                    waitCnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = (state == WAIT);
    assign bus.mem_we    = reqWe;
    assign bus.mem_addr  = reqAddr;
    assign bus.mem_wdata = reqWdata;
    assign bus.ic_ready  = (state == RESP) && !srcDc;
    assign bus.dc_ready  = (state == RESP) && srcDc;
    assign bus.ic_rdata  = icRdata;
    assign bus.dc_rdata  = dcRdata;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = errFlag;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Reference model state, stated in terms of the arbitration rules.
    bit           icPend, dcPend, dcWeM, lastGrantDc, errExp;
    logic [31:0]  icAddrM, dcAddrM;
    logic [127:0] dcWdataM, icExp, dcExp;

    mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

    mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raiseIc(input logic [31:0] a);
        bus.ic_req  = 1'b1;
        bus.ic_addr = a;
        icPend  = 1'b1;
        icAddrM = a;
    endtask

    task automatic raiseDc(input bit we, input logic [31:0] a, input logic [127:0] wd);
        bus.dc_req   = 1'b1;
        bus.dc_we    = we;
        bus.dc_addr  = a;
        bus.dc_wdata = wd;
        dcPend   = 1'b1;
        dcWeM    = we;
        dcAddrM  = a;
        dcWdataM = wd;
    endtask

    task automatic modelReset();
        icPend = 0; dcPend = 0; errExp = 0; lastGrantDc = 0;
        icExp = '0; dcExp = '0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"},     bus.busy, 0);
        check({tag, "_mem_req"},  bus.mem_req, 0);
        check({tag, "_ic_ready"}, bus.ic_ready, 0);
        check({tag, "_dc_ready"}, bus.dc_ready, 0);
    endtask

    // Called in an IDLE cycle with the pending requests already driven.
    // ackAt = WAIT cycle (1-based) in which memory acks; 0 = never.
    task automatic serve(input int ackAt, input logic [127:0] data);
        bit winDc, acked, expWe;
        logic [31:0] expAddr;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        winDc = dcPend && (!icPend || !lastGrantDc);
`else
        winDc = dcPend;
`endif
        expAddr = ((winDc ? dcAddrM : icAddrM) / 32'd16) * 32'd16;
        expWe = winDc && dcWeM;
        lastGrantDc = winDc;
        step();
        check("wait_addr", bus.mem_addr, expAddr);
        check("wait_we",   bus.mem_we, expWe);
        check("wait_busy", bus.busy, 1);
        if (expWe) check("wait_wdata", bus.mem_wdata, dcWdataM);
        acked = 0;
        for (int w = 1; w <= TO; w++) begin
            check("wait_req", bus.mem_req, 1);
            check("wait_err", bus.err, errExp);
            if (w == ackAt) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = data;
                acked = 1;
            end else begin
                bus.mem_rdata = rnd128();
            end
            step();
            bus.mem_ack = 1'b0;
            if (acked) break;
        end
        if (acked) begin
            if (!expWe) begin
                if (winDc) dcExp = data;
                else       icExp = data;
            end
        end else begin
            errExp = 1;
            if (winDc) dcExp = '0;
            else       icExp = '0;
        end
        check("resp_ic_ready", bus.ic_ready, !winDc);
        check("resp_dc_ready", bus.dc_ready, winDc);
        check("resp_ic_rdata", bus.ic_rdata, icExp);
        check("resp_dc_rdata", bus.dc_rdata, dcExp);
        check("resp_err",      bus.err, errExp);
        check("resp_mem_req",  bus.mem_req, 0);
        check("resp_busy",     bus.busy, 1);
        if (winDc) begin bus.dc_req = 1'b0; dcPend = 0; end
        else       begin bus.ic_req = 1'b0; icPend = 0; end
        step();
        checkIdleOutputs("post");
    endtask

    initial begin
        int ackAt;
        bus.ic_req = 0; bus.ic_addr = '0;
        bus.dc_req = 0; bus.dc_we = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        modelReset();

        // Reset state
        rst = 1'b0;
        step(); step();
        checkIdleOutputs("rst");
        check("rst_ic_rdata", bus.ic_rdata, 0);
        check("rst_dc_rdata", bus.dc_rdata, 0);
        check("rst_err",      bus.err, 0);
        check("rst_mem_we",   bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b1;
        step();

        // Single icache fill, ack in the third WAIT cycle
        raiseIc(32'h0000_1004);
        serve(3, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);

        // Collision: dcache write-back wins, then the icache fill
        raiseIc(32'h0000_3008);
        raiseDc(1'b1, 32'h0000_2000, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978);
        serve(1, rnd128());
        serve(2, 128'hCAFE_F00D_0000_0000_1234_5678_9ABC_DEF0);

        // Ack arriving in the last allowed WAIT cycle
        raiseDc(1'b0, 32'h0000_4010, '0);
        serve(TO, 128'h5A5A_A5A5_0000_FFFF_1357_2468_ACE0_BDF1);

        // Watchdog timeout, then a normal request with err still set
        raiseDc(1'b0, 32'h0000_5020, '0);
        serve(0, '0);
        raiseIc(32'h0000_6033);
        serve(2, 128'h1111_2222_3333_4444_5555_6666_7777_8888);

        // Both sides keep re-requesting
        raiseIc(32'h0000_7000);
        raiseDc(1'b0, 32'h0000_8000, '0);
        for (int k = 0; k < 4; k++) begin
            serve(1, rnd128());
            if (!icPend) raiseIc(32'h0000_7000 + 32'(k) * 32'h40);
            if (!dcPend) raiseDc(1'b0, 32'h0000_8000 + 32'(k) * 32'h40, '0);
        end
        if (dcPend || icPend) serve(1, rnd128());
        if (dcPend || icPend) serve(1, rnd128());

        // Reset in the middle of WAIT, stray ack afterwards
        raiseDc(1'b0, 32'h0000_9000, '0);
        step();
        check("mid_mem_req", bus.mem_req, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.dc_req = 1'b0;
        modelReset();
        checkIdleOutputs("midrst");
        check("midrst_err",      bus.err, 0);
        check("midrst_ic_rdata", bus.ic_rdata, 0);
        check("midrst_dc_rdata", bus.dc_rdata, 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        step();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rnd128();
        step();
        bus.mem_ack = 1'b0;
        checkIdleOutputs("stray");
        check("stray_dc_rdata", bus.dc_rdata, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            if (!icPend && $urandom_range(0, 1) == 1) raiseIc($urandom);
            if (!dcPend && $urandom_range(0, 1) == 1)
                raiseDc(1'($urandom_range(0, 1)), $urandom, rnd128());
            if (!icPend && !dcPend)
                raiseDc(1'($urandom_range(0, 1)), $urandom, rnd128());
            ackAt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
            serve(ackAt, rnd128());
        end
        if (dcPend || icPend) serve(1, rnd128());
        if (dcPend || icPend) serve(1, rnd128());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates line-fill and write-back requests from the instruction cache and the data cache onto the single main-memory port.
- Sits directly downstream of the processor's fetch and memory stages' caches. Their miss-induced stalls last exactly as long as this block holds ready low.
- Holds one transaction in flight at a time.
- A watchdog converts a hung memory into a sticky error instead of a permanent pipeline stall.

Parameters:
ADDR_W, 32, byte-address width of all address ports
LINE_W, 128, cache line width in bits (4 words of WORD_SIZE)
TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..2^16-1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
ic_req  input  1  icache line-fill request, level, held until ic_ready
ic_addr  input  ADDR_W  icache line address (low log2(LINE_W/8) bits ignored)
ic_ready  output  1  one-cycle pulse: ic_rdata valid
ic_rdata  output  LINE_W  fill data, held until next icache completion
dc_req  input  1  dcache request, level, held until dc_ready
dc_we  input  1  1 = write-back, 0 = line fill
dc_addr  input  ADDR_W  dcache line address
dc_wdata  input  LINE_W  write-back data
dc_ready  output  1  one-cycle completion pulse
dc_rdata  output  LINE_W  fill data, held until next dcache completion
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  write strobe qualifying mem_req
mem_addr  output  ADDR_W  line-aligned address (low bits forced to 0)
mem_wdata  output  LINE_W  write data
mem_ack  input  1  one-cycle completion; mem_rdata valid this cycle
mem_rdata  input  LINE_W  read data
busy  output  1  state != IDLE
err  output  1  sticky timeout flag

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including ic_rdata, dc_rdata and err.
  - The watchdog counter goes to 0.
  - Priority pointer goes to dcache.
  - Reset mid-transaction abandons it. A mem_ack arriving afterwards in IDLE is ignored.
- States:
  - IDLE:
    - Sample ic_req and dc_req. If either is high, latch the winner (source, we, addr, wdata) and go to WAIT.
    - mem_req rises on the same edge, so the request becomes visible to memory 1 cycle after the cycle in which the req was sampled.
    - Priority: dcache wins ties (it holds the older instruction). An icache write is impossible; mem_we=0 for icache.
  - WAIT:
    - mem_req=1 with stable addr, we and wdata.
    - Counter increments each cycle.
    - On mem_ack: latch mem_rdata into the winner's rdata (reads only; writes leave rdata unchanged) and go to RESP.
    - If the counter reaches TIMEOUT without ack: set err=1, load 0 into the winner's rdata, go to RESP.
    - If ack arrives in the same cycle the counter reaches TIMEOUT, ack wins and err is unchanged.
  - RESP:
    - mem_req=0. The winner's ready=1 for exactly this cycle; the counter clears.
    - Next state is always IDLE.
    - The requestor drops req on the edge ending RESP, so IDLE never re-grants a completed request.
- Minimum latency: req sampled at cycle N, ack at N+1, ready at N+2.
- ic_ready and dc_ready are never high together.
- busy is high in WAIT and RESP.
- err is cleared only by reset.
- Addresses are aligned on latch: the low log2(LINE_W/8) bits become 0.
- A request whose req drops before ready violates the protocol. Behaviour is undefined, but the FSM must still return to IDLE.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined: when both requestors are pending in IDLE, the grant goes to the requestor NOT served by the most recent grant. The pointer updates on every grant; after reset the dcache is favoured.
- Undefined: fixed dcache priority. Sustained dcache traffic may starve the icache.

Test Plan:
- Single icache fill: ic_req=1 at addr 0x0000_1004 in cycle 0; memory acks cycle 3 with 0xDEAD..BEEF -> mem_addr=0x0000_1000, mem_we=0; ic_ready pulse cycle 4; ic_rdata=0xDEAD..BEEF; busy low cycle 5.
- Collision, macro undefined: ic_req and dc_req (write-back 0x2000) both rise cycle 0 -> dcache served first with mem_we=1; icache served next (mem_req rises cycle after dc_ready); no overlap of readies.
- Round-robin (MEM_ARBITER_ROUND_ROBIN_EN): both requestors continuously re-request for 4 transactions -> grant order dc, ic, dc, ic.
- Timeout: TIMEOUT=8, dc fill, memory never acks -> err=1 after 8 WAIT cycles; dc_ready pulse with dc_rdata=0; next request still served normally; err stays 1.
- Ack/timeout tie: ack in exact timeout cycle -> data latched, err stays 0.
- Reset mid-WAIT: rst=0 for one cycle during WAIT, memory acks 2 cycles later -> outputs 0, state IDLE, stray ack produces no ready pulse.
